// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit decoder.
package usb_rx_pkg;

    // Receive decoder states
    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StSe01,
        StErr,
        StWaitJ
    } rx_state_e;

    // Line symbols as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Sync pattern as it reads after LSB-first assembly
    localparam logic [7:0] SYNC_BYTE = 8'b1000_0000;

    localparam int unsigned STUFF_LEN_DEFAULT = 6;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decode and bit-unstuffing front end; qualifies one line sample per strobe.
module usb_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    input  logic count_en,        // high while a packet body is being decoded
    output logic bit_valid,       // data bit to shift in this strobe
    output logic bit_val,         // NRZI-decoded bit
    output logic stuff_violation, // one too many consecutive 1s
    output logic is_se0
);

    localparam int unsigned CntW = $clog2(STUFF_LEN + 1);

    logic            prev_dp_q;
    logic [CntW-1:0] ones_cnt_q;
    logic            at_limit;

    // Decode the current sample against the previous line level
    always_comb begin
        is_se0          = ({d_plus, d_minus} == LINE_SE0);
        bit_val         = (d_plus == prev_dp_q);
        at_limit        = (ones_cnt_q == CntW'(STUFF_LEN));
        // At the limit the bit is either the stuffed 0 or a violation; never data
        bit_valid       = shift_enable && !is_se0 && !at_limit;
        stuff_violation = shift_enable && !is_se0 && at_limit && bit_val;
    end

    // Track previous line level and run length of decoded 1s
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dp_q  <= 1'b1;
            ones_cnt_q <= '0;
        end else if (shift_enable) begin
            if (!is_se0) begin
                prev_dp_q <= d_plus;
            end
            if (!count_en) begin
                ones_cnt_q <= '0;
            end else if (!is_se0) begin
                if (at_limit || !bit_val) begin
                    ones_cnt_q <= '0;
                end else begin
                    ones_cnt_q <= ones_cnt_q + CntW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: packet framing FSM, byte assembly and EOP detection.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       shift_enable,
    output logic       rx_en,
    output logic       byte_rcvd,
    output logic [7:0] data_rx,
    output logic       eop,
    output logic       stuff_err
);

    rx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;

    logic bit_valid;
    logic bit_val;
    logic stuff_violation;
    logic is_se0;
    logic is_k;
    logic is_j;
    logic [7:0] shift_next;

    usb_nrzi_unstuff #(
        .STUFF_LEN(STUFF_LEN)
    ) u_nrzi_unstuff (
        .clk            (clk),
        .rst            (rst),
        .d_plus         (d_plus),
        .d_minus        (d_minus),
        .shift_enable   (shift_enable),
        .count_en       (state_q == StRecv),
        .bit_valid      (bit_valid),
        .bit_val        (bit_val),
        .stuff_violation(stuff_violation),
        .is_se0         (is_se0)
    );

    // Symbol classification; SE1 counts as J
    always_comb begin
        is_k       = ({d_plus, d_minus} == LINE_K);
        is_j       = !is_se0 && d_plus;
        shift_next = {bit_val, shift_q[7:1]};
    end

    // Framing FSM with registered level and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rx_en     <= 1'b0;
            byte_rcvd <= 1'b0;
            data_rx   <= '0;
            eop       <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            byte_rcvd <= 1'b0;
            eop       <= 1'b0;
            stuff_err <= 1'b0;
            if (shift_enable) begin
                unique case (state_q)
                    StIdle: begin
                        // First K is also the first decoded bit of sync
                        if (is_k) begin
                            state_q   <= StRecv;
                            rx_en     <= 1'b1;
                            shift_q   <= shift_next;
                            bit_cnt_q <= 3'd1;
                        end
                    end
                    StRecv: begin
                        if (is_se0) begin
                            state_q <= StSe01;
                        end else if (stuff_violation) begin
                            stuff_err <= 1'b1;
                            rx_en     <= 1'b0;
                            state_q   <= StErr;
                        end else if (bit_valid) begin
                            shift_q   <= shift_next;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_rx   <= shift_next;
                                byte_rcvd <= 1'b1;
                            end
                        end
                    end
                    StSe01: begin
                        // Second SE0 makes a real EOP; anything else was a glitch
                        rx_en   <= 1'b0;
                        state_q <= StWaitJ;
                        if (is_se0) begin
                            eop <= 1'b1;
                        end
                    end
                    StErr: begin
                        if (is_se0) begin
                            state_q <= StWaitJ;
                        end
                    end
                    StWaitJ: begin
                        if (is_j) begin
                            state_q   <= StIdle;
                            bit_cnt_q <= '0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench: encodes byte streams onto the line and checks decoder events.
module tb_usb_rx_bit_decoder;

    localparam int KByte  = 0;
    localparam int KEop   = 1;
    localparam int KStuff = 2;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic       shift_enable;
    logic       rx_en;
    logic       byte_rcvd;
    logic [7:0] data_rx;
    logic       eop;
    logic       stuff_err;

    int errors = 0;
    int checks = 0;

    ev_t        exp_q[$];
    ev_t        pend_q[$];
    logic [7:0] pkt_q[$];

    usb_rx_bit_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .d_plus      (d_plus),
        .d_minus     (d_minus),
        .shift_enable(shift_enable),
        .rx_en       (rx_en),
        .byte_rcvd   (byte_rcvd),
        .data_rx     (data_rx),
        .eop         (eop),
        .stuff_err   (stuff_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_check(input int kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none (t=%0t)",
                     kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == KByte) check("data_rx", {24'd0, data}, {24'd0, e.data});
        end
    endtask

    // Monitor: every output pulse must match the next expected event
    always @(negedge clk) begin
        if (byte_rcvd) mon_check(KByte, data_rx);
        if (eop)       mon_check(KEop, 8'h00);
        if (stuff_err) mon_check(KStuff, 8'h00);
    end

    task automatic send_sym(input logic dp, input logic dm);
        d_plus       = dp;
        d_minus      = dm;
        shift_enable = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        shift_enable = 1'b1;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_sym(1'b1, 1'b0);
    endtask

    // Appends a data bit to the wire bit list, inserting a stuffed 0 (or a
    // violating 1 when requested) after STUFF_LEN consecutive ones.
    task automatic add_bit(inout logic bits[$], inout int ones, input logic b,
                           input bit violate, inout bit violated);
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            if (violate) begin
                bits.push_back(1'b1);
                pend_q.push_back('{bits.size() - 1, KStuff, 8'h00});
                violated = 1'b1;
            end else begin
                bits.push_back(1'b0);
                ones = 0;
            end
        end
    endtask

    // mode: 0 = EOP, 1 = single-SE0 glitch, 2 = stuff violation, 3 = reset after cut bits
    task automatic run_packet(input int partial, input int mode, input int cut);
        logic       bits[$];
        logic [7:0] bv;
        logic       lvl;
        int         ones;
        int         n;
        bit         violated;
        ones     = 0;
        violated = 1'b0;
        pend_q.delete();
        for (int j = 0; j <= pkt_q.size() && !violated; j++) begin
            bv = (j == 0) ? 8'h80 : pkt_q[j-1];
            for (int i = 0; i < 8 && !violated; i++) begin
                bits.push_back(bv[i]);
                ones = bv[i] ? ones + 1 : 0;
                if (i == 7) pend_q.push_back('{bits.size() - 1, KByte, bv});
                if (ones == 6) begin
                    if (mode == 2) begin
                        bits.push_back(1'b1);
                        pend_q.push_back('{bits.size() - 1, KStuff, 8'h00});
                        violated = 1'b1;
                    end else begin
                        bits.push_back(1'b0);
                        ones = 0;
                    end
                end
            end
        end
        if (!violated) begin
            for (int k = 0; k < partial; k++) begin
                add_bit(bits, ones, logic'($urandom_range(0, 1)), 1'b0, violated);
            end
        end
        n = (cut >= 0 && cut < bits.size()) ? cut : bits.size();
        lvl = 1'b1;
        for (int k = 0; k < n; k++) begin
            while (pend_q.size() > 0 && pend_q[0].at == k) exp_q.push_back(pend_q.pop_front());
            if (bits[k] == 1'b0) lvl = ~lvl;
            if (k == 0) check("rx_en_before_k", {31'd0, rx_en}, 32'd0);
            send_sym(lvl, ~lvl);
            if (k == 0) check("rx_en_after_k", {31'd0, rx_en}, 32'd1);
        end
        case (mode)
            0: begin
                send_sym(1'b0, 1'b0);
                check("rx_en_first_se0", {31'd0, rx_en}, 32'd1);
                exp_q.push_back('{0, KEop, 8'h00});
                send_sym(1'b0, 1'b0);
                check("rx_en_after_eop", {31'd0, rx_en}, 32'd0);
                send_sym(1'b1, 1'b0);
            end
            1: begin
                send_sym(1'b0, 1'b0);
                send_sym(1'b1, 1'b0);
                check("rx_en_after_glitch", {31'd0, rx_en}, 32'd0);
            end
            2: begin
                for (int g = 0; g < 4; g++) begin
                    if ($urandom_range(0, 1) == 0) send_sym(1'b1, 1'b0);
                    else send_sym(1'b0, 1'b1);
                end
                check("rx_en_after_stuff_err", {31'd0, rx_en}, 32'd0);
                send_sym(1'b0, 1'b0);
                send_sym(1'b1, 1'b0);
            end
            default: begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                d_plus  = 1'b1;
                d_minus = 1'b0;
                check("rst_rx_en", {31'd0, rx_en}, 32'd0);
                check("rst_byte_rcvd", {31'd0, byte_rcvd}, 32'd0);
                check("rst_data_rx", {24'd0, data_rx}, 32'd0);
                check("rst_eop", {31'd0, eop}, 32'd0);
                check("rst_stuff_err", {31'd0, stuff_err}, 32'd0);
                check("events_before_rst", exp_q.size(), 32'd0);
            end
        endcase
        send_idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int mode;
        rst          = 1'b1;
        d_plus       = 1'b1;
        d_minus      = 1'b0;
        shift_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx_en", {31'd0, rx_en}, 32'd0);
        check("reset_byte_rcvd", {31'd0, byte_rcvd}, 32'd0);
        check("reset_data_rx", {24'd0, data_rx}, 32'd0);
        check("reset_eop", {31'd0, eop}, 32'd0);
        check("reset_stuff_err", {31'd0, stuff_err}, 32'd0);
        rst = 1'b0;
        send_idle(3);

        // Sync only, then sync + OUT PID, then stuffing inside FF/00
        pkt_q.delete();
        run_packet(0, 0, -1);
        pkt_q = '{8'hE1};
        run_packet(0, 0, -1);
        pkt_q = '{8'hFF, 8'h00};
        run_packet(0, 0, -1);
        // Stuff violation, then a fresh sync
        pkt_q = '{8'hFF};
        run_packet(0, 2, -1);
        pkt_q.delete();
        run_packet(0, 0, -1);
        // Two bytes plus a 3-bit partial byte before EOP
        pkt_q = '{8'($urandom), 8'($urandom)};
        run_packet(3, 0, -1);
        // Reset in the middle of byte 2, then a fresh sync
        pkt_q = '{8'hA5, 8'h3C};
        run_packet(0, 3, 11);
        pkt_q.delete();
        run_packet(0, 0, -1);
        // Single-SE0 glitch
        run_packet(2, 1, -1);

        for (int p = 0; p < 25; p++) begin
            pkt_q.delete();
            nb   = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) pkt_q.push_back(8'($urandom));
            if (mode == 2) pkt_q.push_back(8'hFF);
            run_packet($urandom_range(0, 7), mode, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("events_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
Upstream front end of the USB receive path, directly feeding the receive controller. It samples the synchronized D+/D- line once per bit strobe and performs NRZI decoding, bit unstuffing, LSB-first byte assembly and SE0-based EOP detection. It produces the controller's rx_en, byte_rcvd, data_rx and eop inputs, plus a stuff-error flag.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit must be a stuffed 0 and is discarded.

Ports:
clk  in  1  system clock; one clock for the whole block.
rst  in  1  reset; synchronous, active-high.
d_plus  in  1  D+ line, already synchronized to clk.
d_minus  in  1  D- line, already synchronized to clk.
shift_enable  in  1  one-clk strobe per bit time at the bit-centre sample point; all line sampling happens only on this strobe.
rx_en  out  1  level; high while a packet is being received (first K to EOP or abort).
byte_rcvd  out  1  one-clk pulse; data_rx holds a newly completed byte.
data_rx  out  8  last completed byte, LSB first on the wire (sync byte reads 8'b10000000).
eop  out  1  one-clk pulse on a valid EOP.
stuff_err  out  1  one-clk pulse on a bit-stuff violation.

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, prev_dp=1 (J), shift reg=0, bit_cnt=0, ones_cnt=0; rx_en=0, byte_rcvd=0, data_rx=8'h00, eop=0, stuff_err=0.
- Line symbols: J = (1,0), K = (0,1), SE0 = (0,0). SE1 (1,1) is treated as J.
- All updates occur only in cycles with shift_enable=1. byte_rcvd, eop and stuff_err are registered and pulse exactly one clk after the deciding strobe. Between strobes, outputs other than those pulses hold.
- NRZI: decoded bit = 1 if d_plus equals prev_dp, else 0. prev_dp updates on every non-SE0 strobe.
- States:
  - IDLE: on a K strobe -> RECV. rx_en rises one clk later. That K is the first decoded bit (0) and is shifted in (bit_cnt=1).
  - RECV, non-SE0 strobe:
    - If ones_cnt==STUFF_LEN and bit==0: discard the bit; ones_cnt=0; bit_cnt unchanged.
    - If ones_cnt==STUFF_LEN and bit==1: pulse stuff_err; rx_en=0; -> ERR.
    - Otherwise: shift = {bit, shift[7:1]}. ones_cnt = bit ? ones_cnt+1 : 0. bit_cnt increments mod 8. When bit_cnt wraps 7->0: data_rx = the completed shift value, and byte_rcvd pulses.
  - RECV, SE0 strobe: -> SE0_1. Any partial byte (bit_cnt!=0) is discarded silently, with no byte_rcvd.
  - SE0_1:
    - SE0 strobe: pulse eop; rx_en=0; -> WAIT_J.
    - Non-SE0 strobe (single-SE0 glitch): rx_en=0, no eop; -> WAIT_J.
  - ERR: wait for an SE0 strobe -> WAIT_J. Ignore data meanwhile.
  - WAIT_J: on a J strobe: prev_dp=1, bit_cnt=0, ones_cnt=0; -> IDLE.
- A K arriving in WAIT_J is ignored; a new packet requires J idle first.
- rst mid-packet: immediate return to reset values, with no eop or byte_rcvd pulse.
- shift_enable held high for consecutive clks: each clk is a separate sample (used by the bench for speed).

Decomposition:
- Package usb_rx_pkg: rx-decoder state enum (IDLE, RECV, SE0_1, ERR, WAIT_J); line-symbol constants LINE_J, LINE_K, LINE_SE0; SYNC_BYTE=8'b10000000; default STUFF_LEN.
- One natural sub-module, usb_nrzi_unstuff. It holds prev_dp and ones_cnt and outputs bit_valid, bit_val, stuff_violation and is_se0 per strobe. The top keeps the FSM, shift register, bit_cnt and output registers.

Test Plan:
- Sync reception: idle J, then KJKJKJKK strobes -> rx_en=1 one clk after the first K; one byte_rcvd pulse with data_rx=8'h80.
- Sync followed by line pattern encoding PID 8'hE1 (OUT) -> second byte_rcvd with data_rx=8'hE1; no stuff_err.
- Six 1s followed by a stuffed 0, inside data byte 8'hFF then 8'h00 -> stuffed bit discarded; bytes 8'hFF and 8'h00 delivered with correct alignment.
- Six 1s followed by a seventh 1 -> stuff_err pulse, rx_en falls, no further byte_rcvd. After SE0 then J, a fresh sync -> 8'h80 received normally.
- Two full bytes, then 3 bits, then SE0,SE0,J -> eop one-clk pulse after the second SE0; no byte_rcvd for the partial byte; return to IDLE.
- rst asserted in the middle of byte 2 -> all outputs return to 0 on the next clk; the subsequent sync decodes as 8'h80.
